uart_tx: RTL

- 8N1 UART transmitter: the serial-out counterpart of the echo receive path.
- Accepts one byte per valid/ready handshake from the echo/application logic and serialises it LSB-first on `txd`.
- Timing is derived from a per-bit clock-count parameter.
- Sits between the echo core and the board TX pin; single clock domain.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 40 ++++
 rtl/uart_tx.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
//   uart_state_t         - transmitter frame state (IDLE, START, DATA, STOP)
//   DATA_BITS            - payload bits per frame (8N1 framing)
//   DEFAULT_CLKS_PER_BIT - system clocks per bit for a 27 MHz clock at 115200 baud
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 234;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: per-bit clock counter for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_done for one cycle
// on the last count of every bit period.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   clear    - restart the bit period (asserted on frame start)
//   en       - count enable (a frame is in progress)
//   bit_done - one-cycle pulse on the final clock of the current bit
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Held at zero whenever no frame is active so every frame starts aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear || !en) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bit_done = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, idle-high serial line.
// Accepts one byte per tx_valid/tx_ready handshake and serialises it as
// start bit, eight data bits and STOP_BITS stop bits, each CLKS_PER_BIT
// clocks long.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   tx_data  - byte to send, sampled only on handshake
//   tx_valid - producer has a byte
//   tx_ready - transmitter can accept a byte this cycle (state is IDLE)
//   txd      - serial output, driven straight from a flop
//   busy     - a frame is in progress
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    uart_state_t state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        txd_q, txd_d;
    logic        accept;
    logic        bit_done;

    assign tx_ready = (state_q == IDLE);
    assign busy     = !tx_ready;
    assign accept   = tx_valid && tx_ready;
    assign txd      = txd_q;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .en      (busy),
        .bit_done(bit_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
        end
    end

    // txd_d is the line level for the cycle after the edge, so each bit
    // appears on txd exactly when its state begins.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        txd_d     = txd_q;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (accept) begin
                    state_d   = START;
                    shift_d   = tx_data;
                    bit_cnt_d = '0;
                    txd_d     = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    txd_d     = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                        txd_d     = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // Next bit is the one about to reach position 0.
                        txd_d     = shift_q[1];
                    end
                end
            end
            STOP: begin
                txd_d = 1'b1;
                if (bit_done) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

endmodule
